ins_fetch: RTL and testbench
============================

Name: ins_fetch

Overview:
Instruction fetch and program-store stage for the 4-bit CPU.
- Holds a 16x9 instruction memory that is loaded while the core is idle.
- Reads the word addressed by the PC's current value (PC_CURR) and drives INS back to the PC and the datapath in the same cycle.
- Drives the PC's set_pc input to hold the PC at 0 while loading or halted.
- A three-state FSM (LOAD/RUN/HALT) sequences program load, execution and halt-on-self-jump.

Parameters:
INS_W, 9, instruction width
PC_W, 4, program counter width
DEPTH, 16, instruction memory words (must equal 2**PC_W)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
PC_CURR  input  PC_W  current PC value from the PC register
prog_we  input  1  program write strobe; honoured only in LOAD
prog_addr  input  PC_W  program write address
prog_data  input  INS_W  program write data
run  input  1  start or resume execution
stop  input  1  abort execution and return to LOAD
INS  output  INS_W  instruction to the PC and datapath (combinational from memory and state)
ins_valid  output  1  INS is a real fetched instruction this cycle
set_pc  output  1  forces the PC to 0 at the next edge
halted  output  1  FSM is in HALT
retire_cnt  output  8  count of retired instructions (see Optional Feature)

Behaviour:
- Reset (rst=1 at an edge):
  - state becomes LOAD and all 16 memory words are cleared to 9'h000 (NOP).
  - While rst=1, set_pc=1 combinationally, INS=0 and ins_valid=0, so the PC returns to 0 on the same edge.
  - Reset mid-RUN or mid-HALT behaves identically.
- Halt predicate: a word is a halt when INS[8:6]=3'b111 and INS[5:4]=2'b00, i.e. a jump to self.
- LOAD state:
  - Outputs: set_pc=1, INS=0, ins_valid=0, halted=0.
  - prog_we=1 writes prog_data to mem[prog_addr] at the edge.
  - run=1 and stop=0 moves to RUN next edge. A write in that same cycle is still committed.
  - The PC is 0 on entry to RUN.
- RUN state:
  - Outputs: set_pc=0, INS=mem[PC_CURR] (asynchronous read), ins_valid=1, halted=0.
  - stop=1 moves to LOAD.
  - Otherwise, if INS satisfies the halt predicate, move to HALT. The halt word itself is presented with ins_valid=1 for exactly one cycle.
  - prog_we is ignored.
  - PC wrap from 15 to 0 is transparent; the fetch simply reads mem[0].
- HALT state:
  - Outputs: set_pc=1, INS=0, ins_valid=0, halted=1.
  - stop=1 moves to LOAD.
  - Otherwise run=1 moves to RUN, restarting from PC 0.
  - prog_we is ignored.
- Precedence:
  - rst overrides everything.
  - stop beats run when both are high.
  - A halt word fetched while stop=1 goes to LOAD, not HALT.
- Latency: zero-cycle fetch, combinational from PC_CURR to INS. Memory write to readable: 1 cycle.

Optional Feature:
Macro RETIRE_CNT_EN.
- Defined: retire_cnt is an 8-bit counter.
  - Increments on each edge where ins_valid=1.
  - Saturates at 255.
  - Cleared by rst and on the LOAD to RUN transition.
  - Holds in HALT; resumes counting on HALT to RUN.
- Undefined: no counter is built and retire_cnt is tied to 8'h00.

Decomposition:
- Shared package (cpu_pkg) holds:
  - INS_W, PC_W, DEPTH
  - OP_JMP=3'b111
  - the halt offset constant 2'b00
  - the state encoding LOAD/RUN/HALT
  - the halt predicate as a function
- One sub-module, ins_mem: DEPTH x INS_W storage with synchronous write, asynchronous read and synchronous clear-all.
- The FSM and counter live in ins_fetch.

Test Plan:
- Reset, then idle 3 cycles -> set_pc=1, INS=0, ins_valid=0, halted=0, retire_cnt=0.
- In LOAD, write mem[0]=9'h001, mem[1]=9'h002, mem[2]=9'h1C0 (halt), then pulse run -> INS follows PC 0,1,2 as 001, 002, 1C0 with ins_valid=1; next cycle halted=1, set_pc=1; retire_cnt=3 with RETIRE_CNT_EN.
- Assert prog_we to addr 0 with 9'h0AA during RUN, then stop and restart -> mem[0] still 9'h001.
- Program 16 NOPs and run 20 cycles -> PC wraps 15 to 0, INS=0 throughout, ins_valid=1, no halt; retire_cnt=20.
- Assert run=1 and stop=1 together in HALT -> state LOAD next cycle, halted=0.
- Assert rst in cycle 2 of RUN -> next cycle LOAD, all memory reads back 0 after restart, PC=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcodes, fetch FSM encoding and halt predicate for the 4-bit CPU
package cpu_pkg;
   localparam int INS_W = 9;
   localparam int PC_W  = 4;
   localparam int DEPTH = 16;

   localparam logic [2:0] OP_JMP   = 3'b111;
   localparam logic [1:0] HALT_OFS = 2'b00;

   localparam logic [1:0] ST_LOAD = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   // A jump with zero offset targets itself, so the program can never leave it.
   function automatic logic is_halt(input logic [INS_W-1:0] ins);
      return (ins[INS_W-1 -: 3] == OP_JMP) && (ins[INS_W-4 -: 2] == HALT_OFS);
   endfunction
endpackage

// File: rtl/ins_mem.sv
// rtl/ins_mem.sv - instruction store: synchronous write, asynchronous read, synchronous clear-all
module ins_mem #(
   parameter int AW = 4,
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   localparam int N = 1 << AW;

   logic [DW-1:0] mem_q [N];
   logic [DW-1:0] mem_d [N];

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < N; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/ins_fetch.sv
// rtl/ins_fetch.sv - fetch stage with LOAD/RUN/HALT sequencing; RETIRE_CNT_EN adds a saturating retire counter
module ins_fetch
   import cpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [PC_W-1:0]  PC_CURR,
   input  logic             prog_we,
   input  logic [PC_W-1:0]  prog_addr,
   input  logic [INS_W-1:0] prog_data,
   input  logic             run,
   input  logic             stop,
   output logic [INS_W-1:0] INS,
   output logic             ins_valid,
   output logic             set_pc,
   output logic             halted,
   output logic [7:0]       retire_cnt
);
   logic [1:0]       state_q, state_d;
   logic [INS_W-1:0] mem_rdata;
   logic             running;

   ins_mem #(.AW(PC_W), .DW(INS_W)) u_mem (
      .clk   (clk),
      .clr   (rst),
      .we    (prog_we && (state_q == ST_LOAD)),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (PC_CURR),
      .rdata (mem_rdata)
   );

   // Reset must pull the PC to 0 on the same edge, so it masks the outputs directly.
   assign running   = !rst && (state_q == ST_RUN);
   assign INS       = running ? mem_rdata : '0;
   assign ins_valid = running;
   assign set_pc    = !running;
   assign halted    = (state_q == ST_HALT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: if (run && !stop) state_d = ST_RUN;
         ST_RUN: begin
            if (stop)              state_d = ST_LOAD;
            else if (is_halt(INS)) state_d = ST_HALT;
         end
         ST_HALT: begin
            if (stop)     state_d = ST_LOAD;
            else if (run) state_d = ST_RUN;
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_LOAD;
      else     state_q <= state_d;
   end

`ifdef RETIRE_CNT_EN
   logic [7:0] retire_q, retire_d;

   always_comb begin
      retire_d = retire_q;
      if ((state_q == ST_LOAD) && (state_d == ST_RUN)) retire_d = 8'h00;
      else if (ins_valid && (retire_q != 8'hFF))      retire_d = retire_q + 8'h01;
   end

   always_ff @(posedge clk) begin
      if (rst) retire_q <= 8'h00;
      else     retire_q <= retire_d;
   end

   assign retire_cnt = retire_q;
`else
   assign retire_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_ins_fetch.sv
// tb/tb_ins_fetch.sv - self-checking bench for ins_fetch against a behavioural model
module tb_ins_fetch;
   localparam int M_LOAD = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;
`ifdef RETIRE_CNT_EN
   localparam bit RC_EN = 1'b1;
`else
   localparam bit RC_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, prog_we, run, stop;
   logic [3:0] PC_CURR, prog_addr;
   logic [8:0] prog_data, INS;
   logic       ins_valid, set_pc, halted;
   logic [7:0] retire_cnt;

   always #5 clk = ~clk;

   ins_fetch dut (
      .clk(clk), .rst(rst), .PC_CURR(PC_CURR), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .run(run), .stop(stop), .INS(INS), .ins_valid(ins_valid),
      .set_pc(set_pc), .halted(halted), .retire_cnt(retire_cnt)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: program image, operating mode, retire count
   int         mode = M_LOAD;
   logic [8:0] mmem [16];
   int         mcnt = 0;
   bit         model_ok = 1'b0;
   bit         rand_pc = 1'b0;

   always @(posedge clk) begin : model
      bit         c_rst, c_we, c_run, c_stop, live;
      logic [3:0] c_addr, c_pc;
      logic [8:0] c_data, c_ins;
      c_rst = rst; c_we = prog_we; c_run = run; c_stop = stop;
      c_addr = prog_addr; c_data = prog_data; c_pc = PC_CURR;
      live  = model_ok && !c_rst && (mode == M_RUN);
      c_ins = live ? mmem[c_pc] : 9'h000;
      #1;
      if (c_rst || !live) PC_CURR = 4'd0;
      else if (rand_pc && $urandom_range(0, 7) == 0) PC_CURR = 4'($urandom);
      else PC_CURR = c_pc + 4'd1;
      if (c_rst) begin
         model_ok = 1'b1;
         mode = M_LOAD;
         mcnt = 0;
         for (int i = 0; i < 16; i++) mmem[i] = 9'h000;
      end else if (model_ok) begin
         if (mode == M_LOAD) begin
            if (c_we) mmem[c_addr] = c_data;
            if (c_run && !c_stop) begin mode = M_RUN; mcnt = 0; end
         end else if (mode == M_RUN) begin
            if (mcnt < 255) mcnt = mcnt + 1;
            if (c_stop) mode = M_LOAD;
            else if ((c_ins >> 4) == 9'h01C) mode = M_HALT;
         end else begin
            if (c_stop) mode = M_LOAD;
            else if (c_run) mode = M_RUN;
         end
      end
   end

   always @(negedge clk) begin : compare
      bit live;
      #2;
      if (model_ok) begin
         live = !rst && (mode == M_RUN);
         chk("set_pc", 32'(set_pc), 32'(!live));
         chk("ins", 32'(INS), live ? 32'(mmem[PC_CURR]) : 32'd0);
         chk("ins_valid", 32'(ins_valid), 32'(live));
         if (!rst) chk("halted", 32'(halted), 32'(mode == M_HALT));
         chk("retire_cnt", 32'(retire_cnt), RC_EN ? 32'(mcnt) : 32'd0);
      end
   end

   task automatic set_in(input bit r, input bit we, input logic [3:0] a, input logic [8:0] d,
                         input bit ru, input bit st);
      rst = r; prog_we = we; prog_addr = a; prog_data = d; run = ru; stop = st;
   endtask
   task automatic idle();                                      set_in(0, 0, 0, 0, 0, 0); endtask
   task automatic wr(input logic [3:0] a, input logic [8:0] d); set_in(0, 1, a, d, 0, 0); endtask
   task automatic next();                                      @(negedge clk);           endtask

   initial begin
      PC_CURR = 4'd0;
      set_in(1, 0, 0, 0, 0, 0);
      repeat (2) next();

      for (int i = 0; i < 3; i++) begin
         idle();
         if (i == 2) begin
            #3;
            chk("reset_set_pc", 32'(set_pc), 32'd1);
            chk("reset_ins", 32'(INS), 32'd0);
            chk("reset_valid", 32'(ins_valid), 32'd0);
            chk("reset_halted", 32'(halted), 32'd0);
            chk("reset_retire", 32'(retire_cnt), 32'd0);
         end
         next();
      end

      wr(0, 9'h001); next();
      wr(1, 9'h002); next();
      wr(2, 9'h1C0); next();
      set_in(0, 0, 0, 0, 1, 0); next();
      idle(); #3; chk("fetch0", 32'(INS), 32'h001); chk("fetch0_valid", 32'(ins_valid), 32'd1); next();
      idle(); #3; chk("fetch1", 32'(INS), 32'h002); next();
      idle(); #3; chk("fetch2_halt_word", 32'(INS), 32'h1C0); chk("fetch2_valid", 32'(ins_valid), 32'd1); next();
      set_in(0, 0, 0, 0, 1, 0); #3;
      chk("halted_after_halt", 32'(halted), 32'd1);
      chk("set_pc_in_halt", 32'(set_pc), 32'd1);
      chk("retire_after_halt", 32'(retire_cnt), RC_EN ? 32'd3 : 32'd0);
      next();

      set_in(0, 1, 0, 9'h0AA, 0, 0); next();
      set_in(0, 0, 0, 0, 0, 1); next();
      set_in(0, 0, 0, 0, 1, 0); next();
      set_in(0, 0, 0, 0, 0, 1); #3; chk("run_write_ignored", 32'(INS), 32'h001); next();

      for (int i = 0; i < 16; i++) begin wr(4'(i), 9'h000); next(); end
      set_in(0, 0, 0, 0, 1, 0); next();
      for (int i = 0; i < 20; i++) begin idle(); next(); end
      set_in(0, 0, 0, 0, 0, 1); #3;
      chk("wrap_valid", 32'(ins_valid), 32'd1);
      chk("wrap_retire", 32'(retire_cnt), RC_EN ? 32'd20 : 32'd0);
      next();

      wr(0, 9'h1C0); next();
      set_in(0, 0, 0, 0, 1, 0); next();
      idle(); next();
      set_in(0, 0, 0, 0, 1, 1); #3; chk("halt_before_both", 32'(halted), 32'd1); next();
      set_in(0, 0, 0, 0, 1, 0); #3;
      chk("stop_beats_run_halted", 32'(halted), 32'd0);
      chk("stop_beats_run_set_pc", 32'(set_pc), 32'd1);
      next();
      set_in(0, 0, 0, 0, 0, 1); #3; chk("halt_word_with_stop", 32'(INS), 32'h1C0); next();
      idle(); #3; chk("stop_beats_halt", 32'(halted), 32'd0); next();

      wr(0, 9'h005); next();
      wr(1, 9'h006); next();
      wr(2, 9'h007); next();
      set_in(0, 0, 0, 0, 1, 0); next();
      idle(); next();
      set_in(1, 0, 0, 0, 0, 0); #3;
      chk("rst_mid_run_set_pc", 32'(set_pc), 32'd1);
      chk("rst_mid_run_ins", 32'(INS), 32'd0);
      chk("rst_mid_run_valid", 32'(ins_valid), 32'd0);
      next();
      idle(); #3; chk("after_rst_halted", 32'(halted), 32'd0); chk("after_rst_set_pc", 32'(set_pc), 32'd1); next();
      set_in(0, 0, 0, 0, 1, 0); next();
      for (int i = 0; i < 4; i++) begin
         idle(); #3; chk("cleared_mem", 32'(INS), 32'd0); chk("cleared_valid", 32'(ins_valid), 32'd1); next();
      end
      set_in(0, 0, 0, 0, 0, 1); next();

      rand_pc = 1'b1;
      repeat (400) begin
         set_in($urandom_range(0, 49) == 0, 1'($urandom), 4'($urandom),
                ($urandom_range(0, 3) == 0) ? {5'b11100, 4'($urandom)} : 9'($urandom),
                $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
         next();
      end
      idle();
      repeat (2) next();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
